// File: rtl/machine_csr_unit.sv
// machine_csr_unit
//   M-mode CSR file and trap controller. Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval,
//   the cycle and instret counters, a live mip view and a read-only misa. Selects between
//   mret, ecall, ebreak and pending interrupts, then holds a PC redirect towards fetch
//   until fetch acknowledges it.
// Ports
//   clock, reset                  clock; asynchronous active-low reset
//   csr_raddr/csr_ren             read port; csr_rdata/csr_illegal are registered (1 cycle)
//   csr_waddr/csr_wen/csr_wdata   write port (data already merged for set/clear forms)
//   ex_pc                         PC of the instruction in EX, captured into mepc on a trap
//   instr_retire                  increments minstret
//   ecall/ebreak/mret             one-cycle event pulses from decode
//   irq_sw/irq_timer/irq_ext      level interrupt lines (mip bits 3/7/11)
//   irq_local                     level local interrupt lines (mip bits 16+n)
//   redirect_valid/_pc/_is_irq    redirect request to fetch, held until redirect_ack
//   redirect_ack                  fetch accepted the redirect
module machine_csr_unit #(
    parameter int unsigned NUM_LOCAL_IRQ = 16,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE    = 32'h4000_0100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [11:0]          csr_raddr,
    input  logic                 csr_ren,
    input  logic [11:0]          csr_waddr,
    input  logic                 csr_wen,
    input  logic [31:0]          csr_wdata,
    output logic [31:0]          csr_rdata,
    output logic                 csr_illegal,
    input  logic [31:0]          ex_pc,
    input  logic                 instr_retire,
    input  logic                 ecall,
    input  logic                 ebreak,
    input  logic                 mret,
    input  logic                 irq_sw,
    input  logic                 irq_timer,
    input  logic                 irq_ext,
    input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 redirect_is_irq,
    input  logic                 redirect_ack
);

    // Implemented mie bits: MSI, MTI, MEI and the local lines.
    localparam logic [31:0] MieMask =
        32'h0000_0888 | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);
    localparam logic [63:0] CntMask =
        (COUNTER_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << COUNTER_WIDTH) - 64'd1);

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e      state_q, state_d;
    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic [31:0] csr_rdata_q, csr_rdata_d;
    logic        csr_illegal_q, csr_illegal_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect_is_irq_q, redirect_is_irq_d;

    logic [31:0] mip;
    logic [31:0] irq_pending;
    logic        irq_take;
    logic [4:0]  irq_cause;

    // Live interrupt-pending view.
    always_comb begin
        mip     = 32'd0;
        mip[3]  = irq_sw;
        mip[7]  = irq_timer;
        mip[11] = irq_ext;
        for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) begin
            mip[16+i] = irq_local[i];
        end
    end

    // Fixed priority MEI > MSI > MTI > lowest-numbered local line.
    always_comb begin
        irq_pending = mip & mie_q;
        irq_take    = mst_mie_q && (irq_pending != 32'd0);
        irq_cause   = 5'd0;
        if (irq_pending[11]) begin
            irq_cause = 5'd11;
        end else if (irq_pending[3]) begin
            irq_cause = 5'd3;
        end else if (irq_pending[7]) begin
            irq_cause = 5'd7;
        end else begin
            for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--) begin
                if (irq_pending[16+i]) irq_cause = 5'(16 + i);
            end
        end
    end

    // CSR writes, counters and the trap FSM. Trap/mret assignments come last so they
    // override a same-cycle software write to the trap CSRs.
    always_comb begin
        state_d           = state_q;
        mst_mie_d         = mst_mie_q;
        mst_mpie_d        = mst_mpie_q;
        mie_d             = mie_q;
        mtvec_d           = mtvec_q;
        mscratch_d        = mscratch_q;
        mepc_d            = mepc_q;
        mcause_d          = mcause_q;
        mtval_d           = mtval_q;
        redirect_pc_d     = redirect_pc_q;
        redirect_is_irq_d = redirect_is_irq_q;

        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instr_retire};

        if (csr_wen) begin
            case (csr_waddr)
                12'h300: begin
                    mst_mie_d  = csr_wdata[3];
                    mst_mpie_d = csr_wdata[7];
                end
                12'h304: mie_d = csr_wdata & MieMask;
                12'h305: mtvec_d = {csr_wdata[31:2], 1'b0,
                                    VECTORED_EN && (csr_wdata[1:0] == 2'b01)};
                12'h340: mscratch_d = csr_wdata;
                12'h341: mepc_d = {csr_wdata[31:2], 2'b00};
                12'h342: mcause_d = csr_wdata;
                12'h343: mtval_d = csr_wdata;
                12'hB00: mcycle_d = {mcycle_q[63:32], csr_wdata};
                12'hB80: mcycle_d = {csr_wdata, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], csr_wdata};
                12'hB82: minstret_d = {csr_wdata, minstret_q[31:0]};
                default: ;
            endcase
        end
        mcycle_d   = mcycle_d & CntMask;
        minstret_d = minstret_d & CntMask;

        unique case (state_q)
            StIdle: begin
                if (mret) begin
                    mst_mie_d         = mst_mpie_q;
                    mst_mpie_d        = 1'b1;
                    redirect_pc_d     = mepc_q;
                    redirect_is_irq_d = 1'b0;
                    state_d           = StRedirect;
                end else if (ecall || ebreak || irq_take) begin
                    mepc_d            = ex_pc & 32'hFFFF_FFFC;
                    mst_mpie_d        = mst_mie_q;
                    mst_mie_d         = 1'b0;
                    mtval_d           = 32'd0;
                    redirect_is_irq_d = !(ecall || ebreak);
                    redirect_pc_d     = {mtvec_q[31:2], 2'b00};
                    if (ecall) begin
                        mcause_d = 32'd11;
                    end else if (ebreak) begin
                        mcause_d = 32'd3;
                    end else begin
                        mcause_d = {1'b1, 26'd0, irq_cause};
                        if (mtvec_q[0]) begin
                            redirect_pc_d = {mtvec_q[31:2], 2'b00} + {25'd0, irq_cause, 2'b00};
                        end
                    end
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (redirect_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read port. A same-cycle write to the read address returns the post-write value.
    always_comb begin
        logic        use_next;
        logic        hit;
        logic [31:0] val;
        logic        v_mie_bit;
        logic        v_mpie_bit;
        logic [63:0] v_mcycle;
        logic [63:0] v_minstret;

        use_next   = csr_wen && (csr_waddr == csr_raddr);
        v_mie_bit  = use_next ? mst_mie_d : mst_mie_q;
        v_mpie_bit = use_next ? mst_mpie_d : mst_mpie_q;
        v_mcycle   = use_next ? mcycle_d : mcycle_q;
        v_minstret = use_next ? minstret_d : minstret_q;
        hit        = 1'b1;
        val        = 32'd0;

        case (csr_raddr)
            12'h300: val = {19'd0, 2'b11, 3'd0, v_mpie_bit, 3'd0, v_mie_bit, 3'd0};
            12'h301: val = MISA_VALUE;
            12'h304: val = use_next ? mie_d : mie_q;
            12'h305: val = use_next ? mtvec_d : mtvec_q;
            12'h340: val = use_next ? mscratch_d : mscratch_q;
            12'h341: val = use_next ? mepc_d : mepc_q;
            12'h342: val = use_next ? mcause_d : mcause_q;
            12'h343: val = use_next ? mtval_d : mtval_q;
            12'h344: val = mip;
            12'hB00, 12'hC00: val = v_mcycle[31:0];
            12'hB80, 12'hC80: val = v_mcycle[63:32];
            12'hB02, 12'hC02: val = v_minstret[31:0];
            12'hB82, 12'hC82: val = v_minstret[63:32];
            default: hit = 1'b0;
        endcase

        csr_rdata_d   = (csr_ren && hit) ? val : 32'd0;
        csr_illegal_d = csr_ren && !hit;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= StIdle;
            mst_mie_q         <= 1'b0;
            mst_mpie_q        <= 1'b0;
            mie_q             <= 32'd0;
            mtvec_q           <= MTVEC_RESET;
            mscratch_q        <= 32'd0;
            mepc_q            <= 32'd0;
            mcause_q          <= 32'd0;
            mtval_q           <= 32'd0;
            mcycle_q          <= 64'd0;
            minstret_q        <= 64'd0;
            csr_rdata_q       <= 32'd0;
            csr_illegal_q     <= 1'b0;
            redirect_pc_q     <= 32'd0;
            redirect_is_irq_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            mst_mie_q         <= mst_mie_d;
            mst_mpie_q        <= mst_mpie_d;
            mie_q             <= mie_d;
            mtvec_q           <= mtvec_d;
            mscratch_q        <= mscratch_d;
            mepc_q            <= mepc_d;
            mcause_q          <= mcause_d;
            mtval_q           <= mtval_d;
            mcycle_q          <= mcycle_d;
            minstret_q        <= minstret_d;
            csr_rdata_q       <= csr_rdata_d;
            csr_illegal_q     <= csr_illegal_d;
            redirect_pc_q     <= redirect_pc_d;
            redirect_is_irq_q <= redirect_is_irq_d;
        end
    end

    assign csr_rdata       = csr_rdata_q;
    assign csr_illegal     = csr_illegal_q;
    assign redirect_valid  = (state_q == StRedirect);
    assign redirect_pc     = redirect_pc_q;
    assign redirect_is_irq = redirect_is_irq_q;

endmodule

// File: tb/tb_machine_csr_unit.sv
module tb_machine_csr_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] csr_raddr = '0;
    logic        csr_ren = 1'b0;
    logic [11:0] csr_waddr = '0;
    logic        csr_wen = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] ex_pc = '0;
    logic        instr_retire = 1'b0;
    logic        ecall = 1'b0;
    logic        ebreak = 1'b0;
    logic        mret = 1'b0;
    logic        irq_sw = 1'b0;
    logic        irq_timer = 1'b0;
    logic        irq_ext = 1'b0;
    logic [15:0] irq_local = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_is_irq;
    logic        redirect_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    machine_csr_unit dut (
        .clock          (clock),
        .reset          (reset),
        .csr_raddr      (csr_raddr),
        .csr_ren        (csr_ren),
        .csr_waddr      (csr_waddr),
        .csr_wen        (csr_wen),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .ex_pc          (ex_pc),
        .instr_retire   (instr_retire),
        .ecall          (ecall),
        .ebreak         (ebreak),
        .mret           (mret),
        .irq_sw         (irq_sw),
        .irq_timer      (irq_timer),
        .irq_ext        (irq_ext),
        .irq_local      (irq_local),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_is_irq(redirect_is_irq),
        .redirect_ack   (redirect_ack)
    );

    always #5 clock = ~clock;

    // Stimulus tasks start and end just after a falling edge.
    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
        @(negedge clock);
        csr_wen = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
        csr_ren = 1'b1; csr_raddr = a;
        @(negedge clock);
        d = csr_rdata; ill = csr_illegal;
        csr_ren = 1'b0;
    endtask

    task automatic do_ack();
        redirect_ack = 1'b1;
        @(negedge clock);
        redirect_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic ill;
        repeat (2) @(negedge clock);
        checks++;
        if ({redirect_valid, redirect_is_irq, redirect_pc, csr_rdata, csr_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b irq=%b pc=%h rdata=%h ill=%b expected all 0",
                     redirect_valid, redirect_is_irq, redirect_pc, csr_rdata, csr_illegal);
        end
        reset = 1'b1;
        @(negedge clock);
        csr_read(12'h300, d, ill);
        checks++;
        if (d !== 32'h0000_1800) begin
            errors++; $display("FAIL reset_mstatus: got %h expected %h", d, 32'h1800);
        end
        csr_read(12'h305, d, ill);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_mtvec: got %h expected 0", d); end
        csr_read(12'h301, d, ill);
        checks++;
        if (d !== 32'h4000_0100 || ill !== 1'b0) begin
            errors++; $display("FAIL misa: got %h ill=%b expected 40000100 ill=0", d, ill);
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] d; logic ill;
        csr_write(12'h305, 32'h100);
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h80);
        ex_pc = 32'h400;
        irq_timer = 1'b1;
        @(negedge clock);
        irq_timer = 1'b0;
        checks++;
        if ({redirect_valid, redirect_is_irq, redirect_pc} !== {1'b1, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL timer_redirect: got valid=%b irq=%b pc=%h expected 1 1 00000100",
                     redirect_valid, redirect_is_irq, redirect_pc);
        end
        csr_read(12'h342, d, ill);
        checks++;
        if (d !== 32'h8000_0007) begin
            errors++; $display("FAIL timer_mcause: got %h expected 80000007", d);
        end
        csr_read(12'h341, d, ill);
        checks++;
        if (d !== 32'h400) begin errors++; $display("FAIL timer_mepc: got %h expected 400", d); end
        csr_read(12'h300, d, ill);
        checks++;
        if (d !== 32'h1880) begin
            errors++; $display("FAIL timer_mstatus: got %h expected 1880", d);
        end
        do_ack();
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL timer_ack: got valid=%b expected 0", redirect_valid);
        end
    endtask

    task automatic test_vectored_local();
        logic [31:0] d; logic ill;
        csr_write(12'h305, 32'h101);
        csr_write(12'h304, 32'h0004_0000);
        csr_write(12'h300, 32'h8);
        irq_local[2] = 1'b1;
        @(negedge clock);
        irq_local = '0;
        checks++;
        if ({redirect_valid, redirect_is_irq, redirect_pc} !== {1'b1, 1'b1, 32'h148}) begin
            errors++;
            $display("FAIL vectored_redirect: got valid=%b irq=%b pc=%h expected 1 1 00000148",
                     redirect_valid, redirect_is_irq, redirect_pc);
        end
        csr_read(12'h342, d, ill);
        checks++;
        if (d !== 32'h8000_0012) begin
            errors++; $display("FAIL vectored_mcause: got %h expected 80000012", d);
        end
        do_ack();
    endtask

    task automatic test_priority_hold();
        logic [31:0] d; logic ill;
        csr_write(12'h305, 32'h100);
        csr_write(12'h304, 32'h880);
        csr_write(12'h300, 32'h8);
        ex_pc = 32'h500;
        irq_ext = 1'b1; irq_timer = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            ecall = (i == 2);
            ex_pc = 32'h3000;
            @(negedge clock);
            checks++;
            if ({redirect_valid, redirect_is_irq, redirect_pc} !== {1'b1, 1'b1, 32'h100}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b irq=%b pc=%h expected 1 1 00000100",
                         i, redirect_valid, redirect_is_irq, redirect_pc);
            end
        end
        ecall = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0;
        csr_read(12'h342, d, ill);
        checks++;
        if (d !== 32'h8000_000B) begin
            errors++; $display("FAIL priority_mcause: got %h expected 8000000b", d);
        end
        csr_read(12'h341, d, ill);
        checks++;
        if (d !== 32'h500) begin errors++; $display("FAIL hold_mepc: got %h expected 500", d); end
        do_ack();
        do_ack();
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ack: got valid=%b expected 0", redirect_valid);
        end
    endtask

    task automatic test_ecall_mret();
        logic [31:0] d; logic ill;
        csr_write(12'h305, 32'h101);
        csr_write(12'h300, 32'h8);
        ex_pc = 32'h2000;
        ecall = 1'b1;
        csr_wen = 1'b1; csr_waddr = 12'h342; csr_wdata = 32'h55;
        @(negedge clock);
        ecall = 1'b0; csr_wen = 1'b0;
        checks++;
        if ({redirect_valid, redirect_is_irq, redirect_pc} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL ecall_redirect: got valid=%b irq=%b pc=%h expected 1 0 00000100",
                     redirect_valid, redirect_is_irq, redirect_pc);
        end
        csr_read(12'h342, d, ill);
        checks++;
        if (d !== 32'd11) begin errors++; $display("FAIL ecall_mcause: got %h expected b", d); end
        csr_read(12'h341, d, ill);
        checks++;
        if (d !== 32'h2000) begin errors++; $display("FAIL ecall_mepc: got %h expected 2000", d); end
        do_ack();
        ex_pc = 32'h2100;
        mret = 1'b1;
        @(negedge clock);
        mret = 1'b0;
        checks++;
        if ({redirect_valid, redirect_is_irq, redirect_pc} !== {1'b1, 1'b0, 32'h2000}) begin
            errors++;
            $display("FAIL mret_redirect: got valid=%b irq=%b pc=%h expected 1 0 00002000",
                     redirect_valid, redirect_is_irq, redirect_pc);
        end
        csr_read(12'h300, d, ill);
        checks++;
        if (d !== 32'h1888) begin errors++; $display("FAIL mret_mstatus: got %h expected 1888", d); end
        do_ack();
        ebreak = 1'b1;
        @(negedge clock);
        ebreak = 1'b0;
        csr_read(12'h342, d, ill);
        checks++;
        if (d !== 32'd3 || redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL ebreak: got mcause=%h valid=%b expected 3 1", d, redirect_valid);
        end
        do_ack();
    endtask

    task automatic test_csr_rw();
        logic [31:0] d; logic ill;
        csr_wen = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'hCAFE_F00D;
        csr_ren = 1'b1; csr_raddr = 12'h340;
        @(negedge clock);
        csr_wen = 1'b0; csr_ren = 1'b0;
        checks++;
        if (csr_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL same_cycle_rw: got %h expected cafef00d", csr_rdata);
        end
        csr_write(12'h341, 32'h1237);
        csr_read(12'h341, d, ill);
        checks++;
        if (d !== 32'h1234) begin errors++; $display("FAIL mepc_align: got %h expected 1234", d); end
        csr_read(12'h7C0, d, ill);
        checks++;
        if (d !== 32'h0 || ill !== 1'b1) begin
            errors++; $display("FAIL unmapped: got rdata=%h ill=%b expected 0 1", d, ill);
        end
        csr_write(12'h301, 32'h0);
        csr_read(12'h301, d, ill);
        checks++;
        if (d !== 32'h4000_0100 || ill !== 1'b0) begin
            errors++; $display("FAIL misa_ro: got %h ill=%b expected 40000100 0", d, ill);
        end
        irq_sw = 1'b1; irq_local[0] = 1'b1;
        csr_read(12'h344, d, ill);
        irq_sw = 1'b0; irq_local = '0;
        checks++;
        if (d !== 32'h0001_0008) begin errors++; $display("FAIL mip_live: got %h expected 10008", d); end
    endtask

    task automatic test_counters();
        logic [31:0] d; logic ill;
        csr_write(12'hB00, 32'hFFFF_FFFF);
        @(negedge clock);
        csr_read(12'hB00, d, ill);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mcycle_lo_wrap: got %h expected 0", d); end
        csr_read(12'hB80, d, ill);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL mcycle_hi_carry: got %h expected 1", d); end
        csr_read(12'hC80, d, ill);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL cycleh_mirror: got %h expected 1", d); end
        instr_retire = 1'b1;
        csr_write(12'hB02, 32'h5);
        @(negedge clock);
        instr_retire = 1'b0;
        csr_read(12'hB02, d, ill);
        checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL minstret: got %h expected 6", d); end
        csr_read(12'hC02, d, ill);
        checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL instret_mirror: got %h expected 6", d); end
    endtask

    task automatic test_reset_mid_redirect();
        logic [31:0] d; logic ill;
        ebreak = 1'b1;
        @(negedge clock);
        ebreak = 1'b0;
        checks++;
        if (redirect_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_valid: got %b expected 1", redirect_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b pc=%h expected 0 0", redirect_valid, redirect_pc);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        csr_read(12'h342, d, ill);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_mcause: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_timer_irq();
        test_vectored_local();
        test_priority_hold();
        test_ecall_mret();
        test_csr_rw();
        test_counters();
        test_reset_mid_redirect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
